stack_cache: RTL and testbench



---
 rtl/stack_cache.sv | 121 ++++++++++++
 tb/tb_stack_cache.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_cache.sv
// stack_cache: a LIFO stack engine that holds the two topmost entries in
// registers and spills deeper entries to an external synchronous single-port
// RAM. Push and pop each complete in one cycle and never stall. A refill read
// issued by a pop is forwarded straight into top_q when a second pop follows
// immediately, so the one-cycle RAM read latency is never visible.
//
// Command encoding: 0 = NONE, 1 = PUSH, 2 = POP, 3 = CLEAR.
module stack_cache #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       cmd,
    inout  wire  [WIDTH-1:0] data,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    localparam logic [1:0] SC_PUSH  = 2'd1;
    localparam logic [1:0] SC_POP   = 2'd2;
    localparam logic [1:0] SC_CLEAR = 2'd3;

    localparam int            CW  = AW + 2;
    localparam logic [CW-1:0] CAP = CW'((1 << AW) + 2);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [WIDTH-1:0] next_q, next_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] nx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CAP);
    assign err   = err_q;

    // Top-of-stack goes onto the shared bus unless the client is pushing.
    assign data = (cmd != SC_PUSH && !empty) ? top_q : 'z;

    // Next-state and RAM port control, all decided from cmd and current state.
    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        next_d    = next_q;
        pend_d    = pend_q;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        // The second entry is either held in next_q or just arriving from RAM.
        nx        = pend_q ? ram_rdata : next_q;

        case (cmd)
            SC_PUSH: begin
                if (count_q == CAP) begin
                    err_d = 1'b1;
                end else begin
                    top_d   = data;
                    next_d  = top_q;
                    count_d = count_q + CW'(1);
                    pend_d  = 1'b0;
                    // With a refill pending, the old second entry is still
                    // intact in RAM, so no spill is needed and rdata is dropped.
                    if (count_q >= CW'(2) && !pend_q) begin
                        ram_we    = 1'b1;
                        ram_addr  = AW'(count_q - CW'(2));
                        ram_wdata = next_q;
                    end
                end
            end
            SC_POP: begin
                if (count_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    top_d   = nx;
                    count_d = count_q - CW'(1);
                    if (count_q >= CW'(3)) begin
                        ram_addr = AW'(count_q - CW'(3));
                        pend_d   = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                    end
                end
            end
            SC_CLEAR: begin
                count_d = '0;
                pend_d  = 1'b0;
            end
            default: begin
                if (pend_q) begin
                    next_d = ram_rdata;
                    pend_d = 1'b0;
                end
            end
        endcase
    end

    // State registers; reset abandons any refill read in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
            top_q   <= '0;
            next_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            next_q  <= next_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_stack_cache.sv
// Testbench for stack_cache (WIDTH=16, AW=2, capacity 6): table-driven
// directed sequences, a mid-sequence reset, then random commands checked
// against a queue-based LIFO model and an external RAM model.
module tb_stack_cache;

    localparam int W   = 16;
    localparam int AW  = 2;
    localparam int CAP = 6;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_PUSH  = 2'd1;
    localparam logic [1:0] C_POP   = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [1:0]    cmd   = C_NONE;
    wire  [W-1:0]  data;
    logic          empty, full, err;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;

    logic          drv     = 1'b0;
    logic [W-1:0]  drv_val = '0;
    assign data = drv ? drv_val : 'z;

    stack_cache #(.WIDTH(W), .AW(AW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .cmd       (cmd),
        .data      (data),
        .empty     (empty),
        .full      (full),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 Clock = ~Clock;

    // External synchronous single-port RAM, one-cycle read latency.
    logic [W-1:0] mem [4];
    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stack contents, bottom at index 0.
    logic [W-1:0] model[$];
    bit           rd_out = 1'b0;   // previous command was a pop that refilled from RAM

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one command for one clock edge, check against the model, and
    // return what was observed for table comparisons.
    task automatic step(input logic [1:0] c, input logic [W-1:0] v,
                        output logic o_we, output logic [AW-1:0] o_addr,
                        output logic [W-1:0] o_wd, output logic [W-1:0] o_top,
                        output logic o_emp, output logic o_full, output logic o_err);
        int           sz;
        bit           exp_we, exp_err;
        logic [AW-1:0] exp_addr;
        logic [W-1:0]  exp_wd;
        sz = model.size();
        cmd     = c;
        drv     = (c == C_PUSH);
        drv_val = v;
        #1;
        exp_we   = (c == C_PUSH) && sz < CAP && sz >= 2 && !rd_out;
        exp_wd   = exp_we ? model[sz-2] : '0;
        exp_addr = exp_we ? AW'(sz - 2) : ((c == C_POP && sz >= 3) ? AW'(sz - 3) : '0);
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_wdata", ram_wdata, exp_wd);
        chk("we_while_pend", ram_we && rd_out, 0);
        if (c != C_PUSH && sz > 0) chk("data_pre", data, model[sz-1]);
        o_we = ram_we; o_addr = ram_addr; o_wd = ram_wdata;

        exp_err = (c == C_PUSH && sz == CAP) || (c == C_POP && sz == 0);
        rd_out  = (c == C_POP && sz >= 3);
        case (c)
            C_PUSH:  if (sz < CAP) model.push_back(v);
            C_POP:   if (sz > 0) void'(model.pop_back());
            C_CLEAR: model.delete();
            default: ;
        endcase

        @(posedge Clock);
        #1;
        cmd = C_NONE;
        drv = 1'b0;
        #1;
        sz = model.size();
        chk("empty", empty, sz == 0);
        chk("full", full, sz == CAP);
        chk("err", err, exp_err);
        if (sz > 0) chk("top", data, model[sz-1]);
        if (sz >= 3) begin
            bit ok = 1'b1;
            for (int i = 0; i < sz - 2; i++) if (mem[i] !== model[i]) ok = 1'b0;
            chk("ram_contents", ok, 1);
        end
        o_top = data; o_emp = empty; o_full = full; o_err = err;
    endtask

    typedef struct {
        logic [1:0]    c;
        logic [W-1:0]  v;
        logic          chk_top;
        logic [W-1:0]  top;
        logic          emp;
        logic          ful;
        logic          er;
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
    } vec_t;

    function automatic vec_t mk(logic [1:0] c, logic [W-1:0] v, logic chk_top, logic [W-1:0] top,
                                logic emp, logic ful, logic er, logic we, logic [AW-1:0] wa,
                                logic [W-1:0] wd);
        vec_t r;
        r.c = c; r.v = v; r.chk_top = chk_top; r.top = top; r.emp = emp; r.ful = ful;
        r.er = er; r.we = we; r.wa = wa; r.wd = wd;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[$];
        logic          o_we, o_emp, o_full, o_err;
        logic [AW-1:0] o_addr;
        logic [W-1:0]  o_wd, o_top;

        // Fill 1..6 with spills, overflow, then drain and underflow.
        tbl.push_back(mk(C_PUSH, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 2, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 3, 1, 3, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(C_PUSH, 4, 1, 4, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(C_PUSH, 5, 1, 5, 0, 0, 0, 1, 2, 3));
        tbl.push_back(mk(C_PUSH, 6, 1, 6, 0, 1, 0, 1, 3, 4));
        tbl.push_back(mk(C_PUSH, 9, 1, 6, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 0, 0, 1, 0, 1, 0, 0, 0));
        // Back-to-back pop/push/pop with refill bypass.
        tbl.push_back(mk(C_CLEAR,0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 2, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 3, 1, 3, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(C_PUSH, 4, 1, 4, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(C_POP,  0, 1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 7, 1, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Refill latched during idle cycles.
        tbl.push_back(mk(C_CLEAR,0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(C_PUSH, W'(i), 1, W'(i), 0, 0, 0, i >= 3, AW'(i - 3), W'(i - 2)));
        tbl.push_back(mk(C_POP,  0, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_NONE, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_NONE, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 1, 3, 0, 0, 0, 0, 0, 0));
        // Clear then restart from empty.
        tbl.push_back(mk(C_CLEAR,0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(C_PUSH, W'(i), 1, W'(i), 0, 0, 0, i >= 3, AW'(i - 3), W'(i - 2)));
        tbl.push_back(mk(C_CLEAR,0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_PUSH, 8, 1, 8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(C_POP,  0, 0, 0, 1, 0, 0, 0, 0, 0));

        // Reset state.
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        Reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].c, tbl[i].v, o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
            chk($sformatf("v%0d_we", i), o_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("v%0d_waddr", i), o_addr, tbl[i].wa);
                chk($sformatf("v%0d_wdata", i), o_wd, tbl[i].wd);
            end
            chk($sformatf("v%0d_empty", i), o_emp, tbl[i].emp);
            chk($sformatf("v%0d_full", i), o_full, tbl[i].ful);
            chk($sformatf("v%0d_err", i), o_err, tbl[i].er);
            if (tbl[i].chk_top) chk($sformatf("v%0d_top", i), o_top, tbl[i].top);
        end

        // Reset asserted the cycle after a pop whose refill is still in flight.
        step(C_CLEAR, 0, o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        for (int i = 1; i <= 5; i++)
            step(C_PUSH, W'(i), o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        step(C_POP, 0, o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        Reset = 1'b0;
        #1;
        chk("midrst_empty", empty, 1);
        chk("midrst_full", full, 0);
        chk("midrst_err", err, 0);
        chk("midrst_we", ram_we, 0);
        chk("midrst_addr", ram_addr, 0);
        model.delete();
        rd_out = 1'b0;
        @(posedge Clock);
        #2;
        chk("midrst_hold_empty", empty, 1);
        Reset = 1'b1;
        step(C_PUSH, 4, o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        chk("postrst_top", o_top, 4);
        chk("postrst_we", o_we, 0);
        step(C_POP, 0, o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        chk("postrst_count1", o_emp, 1);
        chk("postrst_noerr", o_err, 0);

        // Random commands against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] c;
            r = int'($urandom_range(0, 99));
            if (r < 42)      c = C_PUSH;
            else if (r < 82) c = C_POP;
            else if (r < 97) c = C_NONE;
            else             c = C_CLEAR;
            step(c, W'($urandom), o_we, o_addr, o_wd, o_top, o_emp, o_full, o_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
